// File: rtl/pe_dispatch_controller_if.sv
// Handshake bundle between the dispatch controller, its input feature-map buffer
// and the processing-element array that it drives in lockstep.
interface pe_dispatch_controller_if #(
  parameter int NUM_PE           = 4,
  parameter int BIN_LEN          = 8,
  parameter int INPUT_WIDTH_LOG  = 3,
  parameter int INPUT_HEIGHT_LOG = 3
);
  logic                        start;
  logic                        busy;
  logic                        done;
  logic                        in_rd_en;
  logic [INPUT_WIDTH_LOG-1:0]  in_rd_width_index;
  logic [INPUT_HEIGHT_LOG-1:0] in_rd_height_index;
  logic [BIN_LEN-1:0]          in_rd_val;
  logic [NUM_PE-1:0]           pe_enable;
  logic [BIN_LEN-1:0]          pe_input_val;
  logic [INPUT_WIDTH_LOG-1:0]  pe_input_width_index;
  logic [INPUT_HEIGHT_LOG-1:0] pe_input_height_index;
  logic [NUM_PE-1:0]           pe_done;
  logic [15:0]                 skip_count;

  modport master (
    input  start, in_rd_val, pe_done,
    output busy, done, in_rd_en, in_rd_width_index, in_rd_height_index,
           pe_enable, pe_input_val, pe_input_width_index, pe_input_height_index,
           skip_count
  );

  modport slave (
    output start, in_rd_val, pe_done,
    input  busy, done, in_rd_en, in_rd_width_index, in_rd_height_index,
           pe_enable, pe_input_val, pe_input_width_index, pe_input_height_index,
           skip_count
  );
endinterface

// File: rtl/pe_dispatch_controller.sv
// Walks one input feature map in raster order, broadcasting each pixel to the PE
// array and waiting for every PE to report done; zero pixels can be skipped and counted.
module pe_dispatch_controller #(
  parameter int NUM_PE           = 4,
  parameter int BIN_LEN          = 8,
  parameter int INPUT_WIDTH      = 8,
  parameter int INPUT_HEIGHT     = 8,
  parameter int INPUT_WIDTH_LOG  = 3,
  parameter int INPUT_HEIGHT_LOG = 3,
  parameter int SKIP_ZERO        = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  pe_dispatch_controller_if.master bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    CAPTURE = 3'd2,
    RUN     = 3'd3,
    RELEASE = 3'd4,
    FINISH  = 3'd5
  } state_t;

  localparam bit                          SKIP_EN  = (SKIP_ZERO != 0);
  localparam logic [INPUT_WIDTH_LOG-1:0]  COL_LAST = INPUT_WIDTH_LOG'(INPUT_WIDTH - 1);
  localparam logic [INPUT_HEIGHT_LOG-1:0] ROW_LAST = INPUT_HEIGHT_LOG'(INPUT_HEIGHT - 1);

  state_t                      state_q, state_d;
  logic [INPUT_HEIGHT_LOG-1:0] row_q, row_d;
  logic [INPUT_WIDTH_LOG-1:0]  col_q, col_d;
  logic [15:0]                 skip_q, skip_d;
  logic [NUM_PE-1:0]           mask_q, mask_d;
  logic [NUM_PE-1:0]           en_q, en_d;
  logic [BIN_LEN-1:0]          val_q, val_d;
  logic [INPUT_WIDTH_LOG-1:0]  pw_q, pw_d;
  logic [INPUT_HEIGHT_LOG-1:0] ph_q, ph_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        rd_en_q, rd_en_d;
  logic                        adv_s;
  logic                        last_s;
  logic                        all_done_s;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

  assign last_s     = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign all_done_s = ((mask_q | bus.pe_done) == {NUM_PE{1'b1}});

  // Next-state and registered-output computation for the pixel sequencer.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    skip_d  = skip_q;
    mask_d  = mask_q;
    en_d    = en_q;
    val_d   = val_q;
    pw_d    = pw_q;
    ph_d    = ph_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rd_en_d = 1'b0;
    adv_s   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = FETCH;
          row_d   = {INPUT_HEIGHT_LOG{1'b0}};
          col_d   = {INPUT_WIDTH_LOG{1'b0}};
          skip_d  = 16'd0;
          busy_d  = 1'b1;
          rd_en_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        val_d = bus.in_rd_val;
        pw_d  = col_q;
        ph_d  = row_q;
        if (SKIP_EN && (bus.in_rd_val == {BIN_LEN{1'b0}})) begin
          skip_d = sat_inc16(skip_q);
          adv_s  = 1'b1;
        end else begin
          state_d = RUN;
          en_d    = {NUM_PE{1'b1}};
          mask_d  = {NUM_PE{1'b0}};
        end
      end
      RUN: begin
        // The mask remembers PEs whose done pulse has already come and gone.
        mask_d = mask_q | bus.pe_done;
        if (all_done_s) begin
          state_d = RELEASE;
          en_d    = {NUM_PE{1'b0}};
        end else begin
          state_d = RUN;
        end
      end
      RELEASE: begin
        adv_s = 1'b1;
      end
      FINISH: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (adv_s) begin
      if (last_s) begin
        state_d = FINISH;
        done_d  = 1'b1;
      end else begin
        state_d = FETCH;
        rd_en_d = 1'b1;
        if (col_q == COL_LAST) begin
          col_d = {INPUT_WIDTH_LOG{1'b0}};
          row_d = row_q + INPUT_HEIGHT_LOG'(1);
        end else begin
          col_d = col_q + INPUT_WIDTH_LOG'(1);
        end
      end
    end else begin
      adv_s = 1'b0;
    end
  end

  // State and output registers; reset abandons any pass in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= {INPUT_HEIGHT_LOG{1'b0}};
      col_q   <= {INPUT_WIDTH_LOG{1'b0}};
      skip_q  <= 16'd0;
      mask_q  <= {NUM_PE{1'b0}};
      en_q    <= {NUM_PE{1'b0}};
      val_q   <= {BIN_LEN{1'b0}};
      pw_q    <= {INPUT_WIDTH_LOG{1'b0}};
      ph_q    <= {INPUT_HEIGHT_LOG{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      skip_q  <= skip_d;
      mask_q  <= mask_d;
      en_q    <= en_d;
      val_q   <= val_d;
      pw_q    <= pw_d;
      ph_q    <= ph_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_en_q <= rd_en_d;
    end
  end

  assign bus.busy                  = busy_q;
  assign bus.done                  = done_q;
  assign bus.in_rd_en              = rd_en_q;
  assign bus.in_rd_width_index     = col_q;
  assign bus.in_rd_height_index    = row_q;
  assign bus.pe_enable             = en_q;
  assign bus.pe_input_val          = val_q;
  assign bus.pe_input_width_index  = pw_q;
  assign bus.pe_input_height_index = ph_q;
  assign bus.skip_count            = skip_q;

endmodule
